// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a sprite ROM one pixel per clock and emits clipped, optionally mirrored VGA plots.
// Optional colour-key transparency is compiled in with `define SPRITE_BLITTER_TRANSPARENCY_EN.
module sprite_blitter #(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COLOR_W   = 3,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int SPR_W     = 40,
  parameter int SPR_H     = 40,
  parameter int ADDR_W    = 11,
  parameter int ROM_LAT   = 1,
  parameter int KEY_COLOR = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic               flip,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_plot
);

  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int DRN_W = $clog2(ROM_LAT + 1);

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stateT;

  stateT              state;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [ADDR_W-1:0]  rowBase;
  logic [DRN_W-1:0]   drainCnt;
  logic [X_W-1:0]     xLat;
  logic [Y_W-1:0]     yLat;
  logic               flipLat;

  logic               vld_p0;
  logic [X_W:0]       pixX_p0;
  logic [Y_W:0]       pixY_p0;
  logic               vld_p  [1:ROM_LAT];
  logic [X_W:0]       pixX_p [1:ROM_LAT];
  logic [Y_W:0]       pixY_p [1:ROM_LAT];

  logic               lastCol;
  logic               lastPix;
  logic [COL_W-1:0]   nextCol;
  logic [ROW_W-1:0]   nextRow;
  logic [ADDR_W-1:0]  nextRowBase;
  logic               accept;
  logic               step;
  logic               keyOk;

  // Mirroring reverses the column within the current row only.
  function automatic logic [ADDR_W-1:0] pixAddr(input logic [ADDR_W-1:0] base,
                                                input logic [COL_W-1:0]  c,
                                                input logic              f);
    logic [ADDR_W-1:0] cExt;
    cExt = ADDR_W'(c);
    return base + (f ? (ADDR_W'(SPR_W - 1) - cExt) : cExt);
  endfunction

  function automatic logic onScreen(input logic [X_W:0] x, input logic [Y_W:0] y);
    return (x < (X_W+1)'(SCREEN_W)) && (y < (Y_W+1)'(SCREEN_H));
  endfunction

  always_comb begin
    lastCol     = (col == COL_W'(SPR_W - 1));
    lastPix     = lastCol && (row == ROW_W'(SPR_H - 1));
    nextCol     = lastCol ? '0 : col + 1'b1;
    nextRow     = lastCol ? row + 1'b1 : row;
    nextRowBase = lastCol ? rowBase + ADDR_W'(SPR_W) : rowBase;
    accept      = (state == IDLE) && start;
    step        = (state == RUN) && !lastPix;
  end

  // ---- stage p0: address generation, one pixel per clock ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      rowBase  <= '0;
      drainCnt <= '0;
      xLat     <= '0;
      yLat     <= '0;
      flipLat  <= 1'b0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      vld_p0   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            col      <= '0;
            row      <= '0;
            rowBase  <= '0;
            xLat     <= x0;
            yLat     <= y0;
            flipLat  <= flip;
            rom_addr <= pixAddr('0, '0, flip);
            vld_p0   <= 1'b1;
          end
        end
        RUN: begin
          if (lastPix) begin
            state    <= DRAIN;
            drainCnt <= '0;
            vld_p0   <= 1'b0;
          end else begin
            col      <= nextCol;
            row      <= nextRow;
            rowBase  <= nextRowBase;
            rom_addr <= pixAddr(nextRowBase, nextCol, flipLat);
          end
        end
        DRAIN: begin
          // Covers the ROM latency plus the output register.
          if (drainCnt == DRN_W'(ROM_LAT)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drainCnt <= drainCnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sums carry one extra bit so off-screen pixels are clipped rather than wrapped.
  always_ff @(posedge clk) begin
    if (accept) begin
      pixX_p0 <= {1'b0, x0};
      pixY_p0 <= {1'b0, y0};
    end else if (step) begin
      pixX_p0 <= {1'b0, xLat} + (X_W+1)'(nextCol);
      pixY_p0 <= {1'b0, yLat} + (Y_W+1)'(nextRow);
    end
  end

  // ---- stages p1..pROM_LAT: coordinates travel with the ROM read ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 1; k <= ROM_LAT; k++) vld_p[k] <= 1'b0;
    end else begin
      for (int k = ROM_LAT; k > 1; k--) vld_p[k] <= vld_p[k-1];
      vld_p[1] <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = ROM_LAT; k > 1; k--) begin
      pixX_p[k] <= pixX_p[k-1];
      pixY_p[k] <= pixY_p[k-1];
    end
    pixX_p[1] <= pixX_p0;
    pixY_p[1] <= pixY_p0;
  end

  always_comb begin
    keyOk = !KEY_EN || (rom_data != COLOR_W'(KEY_COLOR));
  end

  // ---- output stage: registered plot to the VGA adapter ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_plot  <= 1'b0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
    end else begin
      vga_plot <= vld_p[ROM_LAT] && keyOk && onScreen(pixX_p[ROM_LAT], pixY_p[ROM_LAT]);
      if (vld_p[ROM_LAT]) begin
        vga_x     <= pixX_p[ROM_LAT][X_W-1:0];
        vga_y     <= pixY_p[ROM_LAT][Y_W-1:0];
        vga_color <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: per-cycle model comparison plus literal spot checks.
module tb_sprite_blitter;

  localparam int SPR_W   = 4;
  localparam int SPR_H   = 2;
  localparam int ROM_LAT = 1;
  localparam int N       = SPR_W * SPR_H;
  localparam int LAST    = N + ROM_LAT + 1;

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  localparam bit KEYED = 1'b1;
`else
  localparam bit KEYED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        flip = 1'b0;
  logic [7:0]  x0 = '0;
  logic [6:0]  y0 = '0;
  logic        busy, done, vgaPlot;
  logic [10:0] romAddr;
  logic [2:0]  romData = '0;
  logic [2:0]  vgaColor;
  logic [7:0]  vgaX;
  logic [6:0]  vgaY;

  int nCmp = 0;
  int nErr = 0;

  bit mActive = 1'b0;
  int mCyc = 0;
  int mX0 = 0;
  int mY0 = 0;
  bit mFlip = 1'b0;
  int plotCnt = 0;

  int logAddr  [0:15];
  int logX     [0:15];
  int logY     [0:15];
  int logColor [0:15];
  int logPlot  [0:15];
  int logDone  [0:15];

  always #5 clk = ~clk;

  // ROM image: data equals the low three address bits, one cycle of latency.
  always @(posedge clk) romData <= romAddr[2:0];

  sprite_blitter #(
    .SPR_W(SPR_W),
    .SPR_H(SPR_H),
    .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .x0(x0),
    .y0(y0),
    .flip(flip),
    .busy(busy),
    .done(done),
    .rom_addr(romAddr),
    .rom_data(romData),
    .vga_x(vgaX),
    .vga_y(vgaY),
    .vga_color(vgaColor),
    .vga_plot(vgaPlot)
  );

  task automatic check(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nErr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pixel p in raster order: row-major sprite walk, mirrored column when flipped.
  function automatic void pixModel(input int p, output int addr, output int x, output int y,
                                   output int color, output bit vis);
    int r;
    int k;
    r = p / SPR_W;
    k = p % SPR_W;
    addr  = r * SPR_W + (mFlip ? (SPR_W - 1 - k) : k);
    x     = mX0 + k;
    y     = mY0 + r;
    color = addr % 8;
    vis   = (x < 160) && (y < 120) && !(KEYED && color == 0);
  endfunction

  task automatic compare();
    int addr, x, y, color, p;
    bit vis;
    if (!resetn) begin
      check("reset outputs", int'({busy, done, vgaPlot, vgaX, vgaY, vgaColor, romAddr}), 0);
    end else if (mActive) begin
      pixModel((mCyc < N) ? mCyc : N - 1, addr, x, y, color, vis);
      check("rom_addr", int'(romAddr), addr);
      check("busy", int'(busy), int'(mCyc <= N + ROM_LAT));
      check("done", int'(done), int'(mCyc == LAST));
      p = mCyc - ROM_LAT - 1;
      if (p >= 0 && p < N) begin
        pixModel(p, addr, x, y, color, vis);
        check("vga_plot", int'(vgaPlot), int'(vis));
        check("vga_x", int'(vgaX), x % 256);
        check("vga_y", int'(vgaY), y % 128);
        check("vga_color", int'(vgaColor), color);
      end else begin
        check("vga_plot empty slot", int'(vgaPlot), 0);
      end
      logAddr[mCyc]  = int'(romAddr);
      logX[mCyc]     = int'(vgaX);
      logY[mCyc]     = int'(vgaY);
      logColor[mCyc] = int'(vgaColor);
      logPlot[mCyc]  = int'(vgaPlot);
      logDone[mCyc]  = int'(done);
      if (vgaPlot) plotCnt++;
    end else begin
      check("idle busy/done/plot", int'({busy, done, vgaPlot}), 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!resetn) begin
      mActive = 1'b0;
    end else if (mActive) begin
      mCyc++;
      if (mCyc > LAST) mActive = 1'b0;
    end else if (start) begin
      mActive = 1'b1;
      mCyc    = 0;
      mX0     = int'(x0);
      mY0     = int'(y0);
      mFlip   = flip;
      plotCnt = 0;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic launch(input int x, input int y, input bit f);
    x0    = 8'(x);
    y0    = 7'(y);
    flip  = f;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic draw(input int x, input int y, input bit f);
    launch(x, y, f);
    repeat (LAST) tick();
  endtask

  initial begin
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    repeat (2) tick();

    // Basic draw
    draw(10, 20, 1'b0);
    check("basic addr cycle5", logAddr[5], 5);
    check("basic first x", logX[2], 10);
    check("basic first y", logY[2], 20);
    check("basic first color", logColor[2], 0);
    check("basic last x", logX[9], 13);
    check("basic last y", logY[9], 21);
    check("basic last color", logColor[9], 7);
    check("basic done cycle10", logDone[10], 1);
    check("basic plot count", plotCnt, KEYED ? 7 : 8);
    tick();

    // Mirror, started at the earliest legal cycle
    draw(10, 20, 1'b1);
    check("mirror addr cycle0", logAddr[0], 3);
    check("mirror addr cycle1", logAddr[1], 2);
    check("mirror addr cycle4", logAddr[4], 7);
    check("mirror first x", logX[2], 10);
    check("mirror first color", logColor[2], 3);
    check("mirror last xy", logX[9] * 1000 + logY[9], 13021);
    check("mirror last color", logColor[9], 4);
    tick();

    // Clipping at the bottom-right corner
    draw(158, 119, 1'b0);
    check("clip plot count", plotCnt, KEYED ? 1 : 2);
    check("clip x159 plotted", logPlot[3], 1);
    check("clip x160 dropped", logPlot[4], 0);
    check("clip row120 dropped", logPlot[6], 0);
    check("clip done cycle10", logDone[10], 1);
    tick();

    // Start while busy is ignored
    launch(30, 40, 1'b0);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (LAST - 4) tick();
    check("handshake plot count", plotCnt, KEYED ? 7 : 8);
    check("handshake done cycle10", logDone[10], 1);
    repeat (4) tick();

    // Asynchronous reset mid-draw
    launch(50, 60, 1'b1);
    repeat (4) tick();
    resetn = 1'b0;
    #1;
    check("async reset immediate", int'({busy, done, vgaPlot, vgaX, vgaY, vgaColor, romAddr}), 0);
    tick();
    resetn = 1'b1;
    repeat (12) tick();

    // Full draw after the aborted one
    draw(100, 5, 1'b0);
    check("post-reset plot count", plotCnt, KEYED ? 7 : 8);
    check("post-reset first x", logX[2], 100);
    check("post-reset done", logDone[10], 1);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised sprite-drawing engine for the VGA game pipeline. It walks a rectangular sprite ROM of any size and issues addresses to it. It tracks the ROM read latency internally and emits per-pixel `x/y/color/plot` writes to the VGA adapter at a runtime-chosen screen origin. New capabilities are runtime horizontal mirroring (one ROM serves both left- and right-facing frames), screen-edge clipping, optional colour-key transparency and a start/busy/done handshake to the game FSM.

## Interface
Parameters:
- `X_W`, 8: VGA x coordinate width.
- `Y_W`, 7: VGA y coordinate width.
- `COLOR_W`, 3: pixel colour width.
- `SCREEN_W`, 160: visible columns; x ≥ SCREEN_W is clipped.
- `SCREEN_H`, 120: visible rows; y ≥ SCREEN_H is clipped.
- `SPR_W`, 40: sprite width in pixels, ≥1.
- `SPR_H`, 40: sprite height in pixels, ≥1.
- `ADDR_W`, 11: ROM address width, 2^ADDR_W ≥ SPR_W*SPR_H.
- `ROM_LAT`, 1: ROM read latency in cycles, ≥1.
- `KEY_COLOR`, 0: transparent colour value (used only with the macro).

Ports:
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  draw request, sampled only in IDLE.
- `x0`  in  X_W  screen column of the sprite's top-left pixel, latched on start.
- `y0`  in  Y_W  screen row of the sprite's top-left pixel, latched on start.
- `flip`  in  1  1 = mirror horizontally, latched on start.
- `busy`  out  1  high from the start-accept edge until the last plot.
- `done`  out  1  one-cycle pulse after the last plot.
- `rom_addr`  out  ADDR_W  sprite ROM address.
- `rom_data`  in  COLOR_W  ROM output, valid ROM_LAT cycles after its address.
- `vga_x`  out  X_W  plot column.
- `vga_y`  out  Y_W  plot row.
- `vga_color`  out  COLOR_W  plot colour.
- `vga_plot`  out  1  write enable to the VGA adapter.

## Operation
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: `start`=1 latches `x0`, `y0` and `flip`, clears `col`, `row` and `row_base`, and moves to RUN.
- RUN issues one address per cycle:
  - `rom_addr = row_base + (flip ? SPR_W-1-col : col)`.
  - `col` increments each cycle.
  - At `col==SPR_W-1`: `col` returns to 0, `row` increments, and `row_base` increases by SPR_W. No multiplier is used.
  - After pixel (SPR_W-1, SPR_H-1) the FSM goes to DRAIN.
- DRAIN: holds for ROM_LAT+1 cycles so the pipeline empties. `rom_addr` holds its last value.
- DONE: asserts `done` for one cycle, then returns to IDLE.
- A pixel-valid bit and the screen coordinates (`x0+col`, `y0+row`) are delayed ROM_LAT stages alongside the ROM access.
- The sums are computed at X_W+1 / Y_W+1 bits, so there is no wrap-around. A pixel whose sum is ≥ SCREEN_W or ≥ SCREEN_H is clipped: `vga_plot`=0 and all counters advance normally.
- Output register: `vga_x`, `vga_y` and `vga_color` (=`rom_data`) load on every valid pixel. `vga_plot` = valid AND in-bounds (AND the key condition, see Configuration).
- `start` is ignored while in RUN, DRAIN or DONE.
- Reset:
  - While `resetn`=0, all outputs are 0: `busy`, `done`, `vga_plot`, `vga_x`, `vga_y`, `vga_color`, `rom_addr`.
  - State returns to IDLE and pipeline valids are cleared.
  - Reset mid-draw aborts immediately and produces no `done`.

## Timing
- Start accepted at edge 0. With N = SPR_W*SPR_H, pixel i's address is driven in cycle i (i = 0..N-1).
- Pixel i's `vga_plot`, `vga_x`, `vga_y` and `vga_color` are presented in cycle i+ROM_LAT+1.
- DRAIN occupies cycles N..N+ROM_LAT. The last plot occurs in cycle N+ROM_LAT.
- `busy`=1 in cycles 0..N+ROM_LAT.
- `done`=1 in cycle N+ROM_LAT+1 only, with `busy`=0.
- The earliest next start is accepted at the edge ending cycle N+ROM_LAT+2 (IDLE).
- Throughput is one pixel per clock, with no bubbles across row wrap.

## Configuration
- `SPRITE_BLITTER_TRANSPARENCY_EN` defined: pixels with `rom_data==KEY_COLOR` produce `vga_plot`=0. They keep their timing slot, and `vga_x/vga_y/vga_color` still update.
- Not defined: every valid in-bounds pixel is plotted, regardless of colour. `KEY_COLOR` is unused.

## Test plan
All scenarios use SPR_W=4, SPR_H=2, ROM_LAT=1, with a ROM model where data = address[2:0].
- Basic draw: start with x0=10, y0=20, flip=0. Addresses 0..7 appear in cycles 0..7. Plots run (10,20)..(13,20) then (10,21)..(13,21), with colours 0..7 in cycles 2..9. `done` pulses in cycle 10; `busy` is high in cycles 0..9.
- Mirror: start with x0=10, y0=20, flip=1. The address sequence is 3,2,1,0,7,6,5,4. Pixel (10,20) has colour 3 and (13,21) has colour 4.
- Clipping: start with x0=158, y0=119. Only (158,119) and (159,119) are plotted. The other six slots have `vga_plot`=0, and `done` still pulses in cycle 10.
- Transparency (macro on, KEY_COLOR=0): the pixels for addresses 0 and 8-wrap produce no plot; the other 7 plots are unchanged. With the macro off, all 8 pixels plot.
- Handshake and reset: a `start` pulse in cycle 3 is ignored, so exactly 8 plots occur. A `resetn` low pulse in cycle 4 of a new draw forces every output to 0 at once and produces no `done`. A subsequent start draws a full sprite.
